// File: rtl/sqrt_operand_issue.sv
// rtl/sqrt_operand_issue.sv - operand unpack/classify and issue stage for the lamp sqrt/inv-sqrt mantissa core
module sqrt_operand_issue #(
    parameter int TIMEOUT_CYC = 64,
    parameter int E_DW        = 8,
    parameter int F_DW        = 7,
    localparam int LAMP_FLOAT_DW = 1 + E_DW + F_DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     op_valid_i,
    output logic                     op_ready_o,
    input  logic [LAMP_FLOAT_DW-1:0] op_i,
    input  logic                     inv_i,
    output logic                     doSqrt_o,
    output logic [F_DW:0]            s_o,
    output logic                     is_exp_odd_o,
    output logic                     invSqrt_o,
    output logic                     special_case_o,
    input  logic                     core_valid_i,
    input  logic [F_DW:0]            core_res_i,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic                     res_sign_o,
    output logic [E_DW-1:0]          res_exp_o,
    output logic [F_DW:0]            res_f_o,
    output logic                     res_special_o,
    output logic [LAMP_FLOAT_DW-1:0] res_special_val_o,
    output logic                     timeout_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [E_DW-1:0]          BIAS = {1'b0, {(E_DW-1){1'b1}}};
    localparam logic [LAMP_FLOAT_DW-1:0] QNAN = {1'b0, {E_DW{1'b1}}, 1'b1, {(F_DW-1){1'b0}}};
    localparam logic [LAMP_FLOAT_DW-1:0] PINF = {1'b0, {E_DW{1'b1}}, {F_DW{1'b0}}};
    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                     r_do_sqrt;
    logic [F_DW:0]            r_s;
    logic                     r_is_exp_odd;
    logic                     r_inv;
    logic                     r_special;
    logic                     r_res_sign;
    logic [E_DW-1:0]          r_res_exp;
    logic [F_DW:0]            r_res_f;
    logic                     r_res_special;
    logic [LAMP_FLOAT_DW-1:0] r_res_special_val;
    logic                     r_timeout;
    logic [CNT_W-1:0]         r_cnt;

    logic                     w_sign;
    logic [E_DW-1:0]          w_exp;
    logic [F_DW-1:0]          w_frac;
    logic                     w_exp_zero;
    logic                     w_exp_max;
    logic                     w_frac_zero;
    logic                     w_special;
    logic [LAMP_FLOAT_DW-1:0] w_special_val;
    logic signed [E_DW:0]     w_e;
    logic signed [E_DW:0]     w_half;
    logic signed [E_DW:0]     w_exp_adj;
    logic                     w_accept;
    logic                     w_cnt_done;

    assign w_sign      = op_i[LAMP_FLOAT_DW-1];
    assign w_exp       = op_i[F_DW +: E_DW];
    assign w_frac      = op_i[F_DW-1:0];
    assign w_exp_zero  = (w_exp == '0);
    assign w_exp_max   = &w_exp;
    assign w_frac_zero = (w_frac == '0);

    // Zero exponent covers denormals too: they are flushed to a signed zero first.
    always_comb begin
        w_special     = 1'b1;
        w_special_val = '0;
        if (w_exp_max && !w_frac_zero) begin
            w_special_val = QNAN;
        end else if (w_exp_zero) begin
            w_special_val = inv_i ? {w_sign, PINF[LAMP_FLOAT_DW-2:0]}
                                  : {w_sign, {(LAMP_FLOAT_DW-1){1'b0}}};
        end else if (w_sign) begin
            w_special_val = QNAN;
        end else if (w_exp_max) begin
            w_special_val = inv_i ? '0 : PINF;
        end else begin
            w_special = 1'b0;
        end
    end

    // Halved unbiased exponent rounds toward minus infinity; odd part goes to the core.
    assign w_e       = $signed({1'b0, w_exp}) - $signed({1'b0, BIAS});
    assign w_half    = w_e >>> 1;
    assign w_exp_adj = $signed({1'b0, BIAS}) + (r_state == S_IDLE && inv_i ? -w_half : w_half);

    assign w_accept   = (r_state == S_IDLE) && op_valid_i;
    assign w_cnt_done = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (op_valid_i) w_state_nxt = S_ISSUE;
            S_ISSUE: if (core_valid_i || w_cnt_done) w_state_nxt = S_OUT;
            S_OUT:   if (res_ready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_do_sqrt         <= 1'b0;
            r_s               <= '0;
            r_is_exp_odd      <= 1'b0;
            r_inv             <= 1'b0;
            r_special         <= 1'b0;
            r_res_sign        <= 1'b0;
            r_res_exp         <= '0;
            r_res_f           <= '0;
            r_res_special     <= 1'b0;
            r_res_special_val <= '0;
            r_timeout         <= 1'b0;
            r_cnt             <= '0;
        end else begin
            if (w_accept) begin
                r_do_sqrt         <= 1'b1;
                r_s               <= {1'b1, w_frac};
                r_is_exp_odd      <= w_e[0];
                r_inv             <= inv_i;
                r_special         <= w_special;
                r_res_special     <= w_special;
                r_res_special_val <= w_special ? w_special_val : '0;
                r_res_sign        <= w_special ? w_special_val[LAMP_FLOAT_DW-1] : 1'b0;
                r_res_exp         <= w_special ? '0 : w_exp_adj[E_DW-1:0];
                r_timeout         <= 1'b0;
                r_cnt             <= '0;
            end else if (r_state == S_ISSUE) begin
                if (core_valid_i) begin
                    r_res_f   <= core_res_i;
                    r_do_sqrt <= 1'b0;
                end else if (w_cnt_done) begin
                    r_do_sqrt         <= 1'b0;
                    r_res_special     <= 1'b1;
                    r_res_special_val <= QNAN;
                    r_timeout         <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (r_state == S_OUT && res_ready_i) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign op_ready_o        = (r_state == S_IDLE);
    assign res_valid_o       = (r_state == S_OUT);
    assign doSqrt_o          = r_do_sqrt;
    assign s_o               = r_s;
    assign is_exp_odd_o      = r_is_exp_odd;
    assign invSqrt_o         = r_inv;
    assign special_case_o    = r_special;
    assign res_sign_o        = r_res_sign;
    assign res_exp_o         = r_res_exp;
    assign res_f_o           = r_res_f;
    assign res_special_o     = r_res_special;
    assign res_special_val_o = r_res_special_val;
    assign timeout_o         = r_timeout;

endmodule

// File: tb/tb_sqrt_operand_issue.sv
// tb/tb_sqrt_operand_issue.sv - directed vector bench for sqrt_operand_issue
module tb_sqrt_operand_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid_i;
    logic        op_ready_o;
    logic [15:0] op_i;
    logic        inv_i;
    logic        doSqrt_o;
    logic [7:0]  s_o;
    logic        is_exp_odd_o;
    logic        invSqrt_o;
    logic        special_case_o;
    logic        core_valid_i;
    logic [7:0]  core_res_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic        res_sign_o;
    logic [7:0]  res_exp_o;
    logic [7:0]  res_f_o;
    logic        res_special_o;
    logic [15:0] res_special_val_o;
    logic        timeout_o;

    int n_cmp = 0;
    int n_bad = 0;

    sqrt_operand_issue #(.TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst(rst),
        .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_i(op_i), .inv_i(inv_i),
        .doSqrt_o(doSqrt_o), .s_o(s_o), .is_exp_odd_o(is_exp_odd_o), .invSqrt_o(invSqrt_o),
        .special_case_o(special_case_o), .core_valid_i(core_valid_i), .core_res_i(core_res_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_sign_o(res_sign_o),
        .res_exp_o(res_exp_o), .res_f_o(res_f_o), .res_special_o(res_special_o),
        .res_special_val_o(res_special_val_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] op;
        logic        inv;
        logic        special;
        logic [15:0] sval;
        logic [7:0]  s;
        logic        odd;
        logic [7:0]  rexp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [15:0] op, input logic inv);
        chk("op_ready_idle", 32'(op_ready_o), 32'd1);
        op_valid_i = 1'b1;
        op_i       = op;
        inv_i      = inv;
        tick();
        op_valid_i = 1'b0;
    endtask

    task automatic drain();
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        chk("res_valid_cleared", 32'(res_valid_o), 32'd0);
        chk("op_ready_back", 32'(op_ready_o), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input logic [7:0] core);
        accept(v.op, v.inv);
        chk("issue_doSqrt", 32'(doSqrt_o), 32'd1);
        chk("issue_special", 32'(special_case_o), 32'(v.special));
        chk("issue_inv", 32'(invSqrt_o), 32'(v.inv));
        chk("issue_op_ready", 32'(op_ready_o), 32'd0);
        if (!v.special) begin
            chk("issue_s", 32'(s_o), 32'(v.s));
            chk("issue_odd", 32'(is_exp_odd_o), 32'(v.odd));
        end
        tick();
        chk("doSqrt_held", 32'(doSqrt_o), 32'd1);
        chk("no_early_valid", 32'(res_valid_o), 32'd0);
        core_valid_i = 1'b1;
        core_res_i   = core;
        tick();
        core_valid_i = 1'b0;
        chk("out_valid", 32'(res_valid_o), 32'd1);
        chk("out_doSqrt_low", 32'(doSqrt_o), 32'd0);
        chk("out_res_f", 32'(res_f_o), 32'(core));
        chk("out_res_special", 32'(res_special_o), 32'(v.special));
        chk("out_timeout", 32'(timeout_o), 32'd0);
        if (v.special) begin
            chk("out_special_val", 32'(res_special_val_o), 32'(v.sval));
        end else begin
            chk("out_res_exp", 32'(res_exp_o), 32'(v.rexp));
            chk("out_res_sign", 32'(res_sign_o), 32'd0);
        end
        drain();
    endtask

    initial begin
        int cyc;

        vecs.push_back('{16'h4080, 1'b0, 1'b0, 16'h0000, 8'h80, 1'b0, 8'd128});
        vecs.push_back('{16'h4000, 1'b0, 1'b0, 16'h0000, 8'h80, 1'b1, 8'd127});
        vecs.push_back('{16'h4000, 1'b1, 1'b0, 16'h0000, 8'h80, 1'b1, 8'd127});
        vecs.push_back('{16'h4080, 1'b1, 1'b0, 16'h0000, 8'h80, 1'b0, 8'd126});
        vecs.push_back('{16'h3F00, 1'b0, 1'b0, 16'h0000, 8'h80, 1'b1, 8'd126});
        vecs.push_back('{16'h3F00, 1'b1, 1'b0, 16'h0000, 8'h80, 1'b1, 8'd128});
        vecs.push_back('{16'h3E80, 1'b0, 1'b0, 16'h0000, 8'h80, 1'b0, 8'd126});
        vecs.push_back('{16'h40C0, 1'b0, 1'b0, 16'h0000, 8'hC0, 1'b0, 8'd128});
        vecs.push_back('{16'h4140, 1'b1, 1'b0, 16'h0000, 8'hC0, 1'b1, 8'd126});
        vecs.push_back('{16'hBF80, 1'b0, 1'b1, 16'h7FC0, 8'h00, 1'b0, 8'd0});
        vecs.push_back('{16'h0000, 1'b1, 1'b1, 16'h7F80, 8'h00, 1'b0, 8'd0});
        vecs.push_back('{16'h8000, 1'b0, 1'b1, 16'h8000, 8'h00, 1'b0, 8'd0});
        vecs.push_back('{16'h8000, 1'b1, 1'b1, 16'hFF80, 8'h00, 1'b0, 8'd0});
        vecs.push_back('{16'h7F80, 1'b0, 1'b1, 16'h7F80, 8'h00, 1'b0, 8'd0});
        vecs.push_back('{16'h7F80, 1'b1, 1'b1, 16'h0000, 8'h00, 1'b0, 8'd0});
        vecs.push_back('{16'hFF80, 1'b0, 1'b1, 16'h7FC0, 8'h00, 1'b0, 8'd0});
        vecs.push_back('{16'h7FC1, 1'b1, 1'b1, 16'h7FC0, 8'h00, 1'b0, 8'd0});
        vecs.push_back('{16'h0001, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 8'd0});
        vecs.push_back('{16'hBF80, 1'b1, 1'b1, 16'h7FC0, 8'h00, 1'b0, 8'd0});

        rst = 1'b0; op_valid_i = 1'b0; op_i = '0; inv_i = 1'b0;
        core_valid_i = 1'b0; core_res_i = '0; res_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_op_ready", 32'(op_ready_o), 32'd1);
        chk("rst_doSqrt", 32'(doSqrt_o), 32'd0);
        chk("rst_res_valid", 32'(res_valid_o), 32'd0);
        chk("rst_s", 32'(s_o), 32'd0);
        chk("rst_special_val", 32'(res_special_val_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], 8'(8'hA5 ^ i));
        end

        core_valid_i = 1'b1;
        core_res_i   = 8'h33;
        tick();
        core_valid_i = 1'b0;
        chk("idle_core_valid_ignored", 32'(res_valid_o), 32'd0);
        chk("idle_still_ready", 32'(op_ready_o), 32'd1);

        // Timeout abort, then a stalled OUT state with a competing operand.
        accept(16'h4080, 1'b0);
        cyc = 0;
        while (doSqrt_o && cyc < 200) begin
            cyc++;
            tick();
        end
        chk("timeout_issue_cycles", 32'(cyc), 32'd64);
        chk("timeout_valid", 32'(res_valid_o), 32'd1);
        chk("timeout_flag", 32'(timeout_o), 32'd1);
        chk("timeout_special", 32'(res_special_o), 32'd1);
        chk("timeout_val", 32'(res_special_val_o), 32'h7FC0);
        op_valid_i = 1'b1;
        op_i       = 16'h4000;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_op_ready", 32'(op_ready_o), 32'd0);
            chk("stall_valid", 32'(res_valid_o), 32'd1);
            chk("stall_timeout", 32'(timeout_o), 32'd1);
            chk("stall_val", 32'(res_special_val_o), 32'h7FC0);
            chk("stall_doSqrt", 32'(doSqrt_o), 32'd0);
        end
        op_valid_i = 1'b0;
        drain();
        chk("timeout_cleared", 32'(timeout_o), 32'd0);

        // core valid arriving on the last allowed ISSUE cycle wins over the timeout.
        accept(16'h4000, 1'b0);
        repeat (63) tick();
        chk("last_cycle_doSqrt", 32'(doSqrt_o), 32'd1);
        core_valid_i = 1'b1;
        core_res_i   = 8'hB7;
        tick();
        core_valid_i = 1'b0;
        chk("edge_valid", 32'(res_valid_o), 32'd1);
        chk("edge_no_timeout", 32'(timeout_o), 32'd0);
        chk("edge_not_special", 32'(res_special_o), 32'd0);
        chk("edge_res_f", 32'(res_f_o), 32'hB7);
        chk("edge_res_exp", 32'(res_exp_o), 32'd127);
        drain();

        // Asynchronous reset in the middle of ISSUE.
        accept(16'h4080, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_doSqrt", 32'(doSqrt_o), 32'd0);
        chk("midrst_s", 32'(s_o), 32'd0);
        chk("midrst_op_ready", 32'(op_ready_o), 32'd1);
        chk("midrst_res_valid", 32'(res_valid_o), 32'd0);
        chk("midrst_res_exp", 32'(res_exp_o), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        run_vec(vecs[0], 8'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
